barrel_fetch: RTL and testbench

Fetch stage of the barrel RISC-V core. It holds one program counter per hardware thread and picks the next enabled thread round-robin every unstalled cycle. It presents that thread's PC, PC+4 and thread ID to the instruction memory and to the fetch/decode pipeline register. It accepts per-thread PC redirects from the execute stage (taken branches and jumps).

---
 rtl/barrel_fetch.sv | 82 ++++++++
 tb/tb_barrel_fetch.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/barrel_fetch.sv
// Barrel-processor fetch stage: one PC per hardware thread, round-robin thread
// selection each unstalled cycle, and per-thread PC redirects from execute.
module barrel_fetch #(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       NUM_THREADS   = 8,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = {ADDRESS_WIDTH{1'b0}},
    localparam int                      BITS_THREADS  = $clog2(NUM_THREADS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic [NUM_THREADS-1:0]   thread_en,
    input  logic                     redirect_valid,
    input  logic [BITS_THREADS-1:0]  redirect_tid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    output logic [ADDRESS_WIDTH-1:0] pc_f,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4_f,
    output logic [BITS_THREADS-1:0]  tid_f,
    output logic                     valid_f
);

    logic [ADDRESS_WIDTH-1:0] pc_q [NUM_THREADS];
    logic [ADDRESS_WIDTH-1:0] pc_d [NUM_THREADS];
    logic [BITS_THREADS-1:0]  tid_q;
    logic [BITS_THREADS-1:0]  tid_d;
    logic [BITS_THREADS-1:0]  next_tid;
    logic [BITS_THREADS-1:0]  cand;
    logic                     unused_redirect_lsbs;

    // Instructions are word aligned, so the low address bits are dropped.
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign tid_f      = tid_q;
    assign pc_f       = pc_q[tid_q];
    assign imem_addr  = pc_q[tid_q];
    assign pc_plus4_f = pc_f + ADDRESS_WIDTH'(4);
    assign valid_f    = thread_en[tid_q] & ~(redirect_valid & (redirect_tid == tid_q));

    // Search tid_q+1 .. tid_q+N (mod N); the downward loop lets the nearest
    // enabled thread win, with tid_q itself considered last.
    always_comb begin
        next_tid = tid_q + BITS_THREADS'(1);
        cand     = '0;
        for (int k = NUM_THREADS; k >= 1; k--) begin
            cand = tid_q + BITS_THREADS'(k);
            if (thread_en[cand]) begin
                next_tid = cand;
            end
        end
    end

    always_comb begin
        pc_d  = pc_q;
        tid_d = tid_q;
        if (!stall) begin
            tid_d = next_tid;
            if (thread_en[tid_q]) begin
                pc_d[tid_q] = pc_plus4_f;
            end
        end
        // Applied last so a redirect overrides the +4 on the same thread.
        if (redirect_valid) begin
            pc_d[redirect_tid] = {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tid_q <= '0;
            for (int i = 0; i < NUM_THREADS; i++) begin
                pc_q[i] <= RESET_PC;
            end
        end else begin
            tid_q <= tid_d;
            for (int i = 0; i < NUM_THREADS; i++) begin
                pc_q[i] <= pc_d[i];
            end
        end
    end

endmodule

// File: tb/tb_barrel_fetch.sv
// Directed bench for barrel_fetch: expected fetch slots are queued as stimulus
// is applied and compared against the DUT outputs half a cycle later.
module tb_barrel_fetch;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [7:0]  thread_en;
    logic        redirect_valid;
    logic [2:0]  redirect_tid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] pc_f;
    logic [31:0] pc_plus4_f;
    logic [2:0]  tid_f;
    logic        valid_f;

    int vectors     = 0;
    int miscompares = 0;

    // {valid, tid, pc}
    logic [35:0] exp_q[$];
    logic [31:0] pcm [8];

    barrel_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .thread_en      (thread_en),
        .redirect_valid (redirect_valid),
        .redirect_tid   (redirect_tid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .pc_f           (pc_f),
        .pc_plus4_f     (pc_plus4_f),
        .tid_f          (tid_f),
        .valid_f        (valid_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_exp(input logic v, input logic [2:0] t, input logic [31:0] pc);
        exp_q.push_back({v, t, pc});
    endtask

    task automatic check_pop(input string tag);
        logic [35:0] e;
        logic [31:0] e_pc;
        logic [31:0] e_pc4;
        #1;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s scoreboard empty", tag);
            return;
        end
        e     = exp_q.pop_front();
        e_pc  = e[31:0];
        e_pc4 = e_pc + 32'd4;
        vectors++;
        assert (tid_f === e[34:32]) else begin
            miscompares++;
            $error("FAIL %s tid_f got %0d exp %0d", tag, tid_f, e[34:32]);
        end
        vectors++;
        assert (pc_f === e_pc) else begin
            miscompares++;
            $error("FAIL %s pc_f got %h exp %h", tag, pc_f, e_pc);
        end
        vectors++;
        assert (imem_addr === e_pc) else begin
            miscompares++;
            $error("FAIL %s imem_addr got %h exp %h", tag, imem_addr, e_pc);
        end
        vectors++;
        assert (pc_plus4_f === e_pc4) else begin
            miscompares++;
            $error("FAIL %s pc_plus4_f got %h exp %h", tag, pc_plus4_f, e_pc4);
        end
        vectors++;
        assert (valid_f === e[35]) else begin
            miscompares++;
            $error("FAIL %s valid_f got %b exp %b", tag, valid_f, e[35]);
        end
    endtask

    // One fetch cycle: expect thread t with its model PC, optionally advance it.
    task automatic step(input string tag, input int t, input logic v, input logic inc);
        push_exp(v, 3'(t), pcm[t]);
        check_pop(tag);
        if (inc) pcm[t] = pcm[t] + 32'd4;
        tick();
    endtask

    initial begin
        rst            = 1'b1;
        stall          = 1'b0;
        thread_en      = 8'hFF;
        redirect_valid = 1'b0;
        redirect_tid   = 3'd0;
        redirect_pc    = 32'h0;
        for (int i = 0; i < 8; i++) pcm[i] = 32'h0;

        // Reset state
        push_exp(1'b1, 3'd0, 32'h0);
        check_pop("reset");
        @(negedge clk);
        rst = 1'b0;

        // All threads enabled: 0..7 at pc 0, then 0..7 at pc 4
        for (int c = 0; c < 16; c++) step("rr_all", c % 8, 1'b1, 1'b1);

        // Sparse mask 0,2,5
        thread_en = 8'b0010_0101;
        for (int c = 0; c < 2; c++) begin
            step("rr_sparse", 0, 1'b1, 1'b1);
            step("rr_sparse", 2, 1'b1, 1'b1);
            step("rr_sparse", 5, 1'b1, 1'b1);
        end

        // Stall with a redirect to thread 3 inside the stall window
        thread_en = 8'hFF;
        step("pre_stall", 0, 1'b1, 1'b1);
        step("pre_stall", 1, 1'b1, 1'b1);
        stall = 1'b1;
        step("stall", 2, 1'b1, 1'b0);
        redirect_valid = 1'b1;
        redirect_tid   = 3'd3;
        redirect_pc    = 32'h100;
        step("stall_redir", 2, 1'b1, 1'b0);
        pcm[3] = 32'h100;
        redirect_valid = 1'b0;
        step("stall", 2, 1'b1, 1'b0);
        stall = 1'b0;
        for (int t = 2; t < 8; t++) step("post_stall", t, 1'b1, 1'b1);

        // Kill: redirect the fetching thread to an unaligned target
        for (int t = 0; t < 4; t++) step("pre_kill", t, 1'b1, 1'b1);
        redirect_valid = 1'b1;
        redirect_tid   = 3'd4;
        redirect_pc    = 32'h203;
        step("kill", 4, 1'b0, 1'b0);
        pcm[4] = 32'h200;
        redirect_valid = 1'b0;
        for (int t = 5; t < 12; t++) step("post_kill", t % 8, 1'b1, 1'b1);
        step("kill_target", 4, 1'b1, 1'b1);

        // No thread enabled: pointer keeps wrapping, no PC moves
        thread_en = 8'h00;
        for (int c = 5; c < 14; c++) step("en_none", c % 8, 1'b0, 1'b0);
        thread_en = 8'h08;
        step("en_08_sel", 6, 1'b0, 1'b0);
        step("en_08", 3, 1'b1, 1'b1);
        step("en_08", 3, 1'b1, 1'b1);

        // PC wrap on thread 4
        thread_en      = 8'hFF;
        redirect_valid = 1'b1;
        redirect_tid   = 3'd4;
        redirect_pc    = 32'hFFFF_FFFC;
        step("wrap_setup", 3, 1'b1, 1'b1);
        pcm[4] = 32'hFFFF_FFFC;
        redirect_valid = 1'b0;
        step("wrap", 4, 1'b1, 1'b1);
        step("after_wrap", 5, 1'b1, 1'b1);
        step("after_wrap", 6, 1'b1, 1'b1);

        // Asynchronous reset between edges, with a redirect that must be lost
        #3;
        rst            = 1'b1;
        redirect_valid = 1'b1;
        redirect_tid   = 3'd0;
        redirect_pc    = 32'h500;
        for (int i = 0; i < 8; i++) pcm[i] = 32'h0;
        push_exp(1'b0, 3'd0, 32'h0);
        check_pop("async_rst");
        @(negedge clk);
        rst            = 1'b0;
        redirect_valid = 1'b0;
        step("post_rst", 0, 1'b1, 1'b1);
        step("post_rst", 1, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
